// File: rtl/cg_pkg.sv
// Shared types and constants for the matrix-op stimulus feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cg_pkg;

    localparam int DW     = 7;
    localparam int OPW    = 4;
    localparam int N_DATA = 64;
    localparam int N_OP   = 15;
    localparam int N_RES  = 16;

    localparam int AW  = $clog2(N_DATA);
    localparam int OAW = $clog2(N_OP);
    localparam int RCW = $clog2(N_RES + 1);

    typedef logic signed [DW-1:0] data_t;
    typedef logic [OPW-1:0]       op_t;
    typedef logic [AW-1:0]        addr_t;

    typedef enum logic [2:0] {
        S_LOAD,
        S_GAP,
        S_SEND,
        S_WAIT,
        S_RES,
        S_CHECK
    } state_t;

    localparam addr_t LAST_ADDR = addr_t'(N_DATA - 1);

    // Opcodes ride only on the first N_OP beats of a pattern.
    function automatic logic is_op_beat(input addr_t a);
        return a < addr_t'(N_OP);
    endfunction

endpackage

// File: rtl/cg_pattern_buf.sv
// One-pattern store: N_DATA element RAM plus N_OP opcode register file.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none; the owner sequences writes and reads.
module cg_pattern_buf
    import cg_pkg::*;
(
    input  logic           clk,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic [OPW-1:0] wr_op,
    input  logic [AW-1:0]  rd_addr,
    output logic [DW-1:0]  rd_data,
    output logic [OPW-1:0] rd_op
);

    data_t          elem_mem [N_DATA];
    op_t            op_mem   [N_OP];
    logic [OAW-1:0] wr_op_idx;
    logic [OAW-1:0] rd_op_idx;

    // Opcode index is forced to 0 on element-only beats so it never leaves the file.
    assign wr_op_idx = is_op_beat(wr_addr) ? wr_addr[OAW-1:0] : '0;
    assign rd_op_idx = is_op_beat(rd_addr) ? rd_addr[OAW-1:0] : '0;

    // Host write port; contents need no reset because a pattern is always fully written before replay.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            elem_mem[wr_addr] <= wr_data;
            if (is_op_beat(wr_addr)) begin
                op_mem[wr_op_idx] <= wr_op;
            end
        end
    end

    assign rd_data = elem_mem[rd_addr];
    assign rd_op   = is_op_beat(rd_addr) ? op_mem[rd_op_idx] : '0;

endmodule

// File: rtl/cg_stim_feeder.sv
// Buffers one host pattern, replays it as a gap-free N_DATA-beat burst, then polices the core's result burst.
// Latency: burst starts GAP+1 cycles after the last host accept; res_* trail core outputs by one cycle.
// Backpressure: h_ready is high only in LOAD; one pattern in flight, the core burst itself is never stalled.
module cg_stim_feeder
    import cg_pkg::*;
#(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_cg_en,
    input  logic           h_valid,
    output logic           h_ready,
    input  logic [DW-1:0]  h_data,
    input  logic [OPW-1:0] h_op,
    output logic           cg_en,
    output logic           in_valid,
    output logic [DW-1:0]  in_data,
    output logic [OPW-1:0] op,
    input  logic           core_out_valid,
    input  logic [DW-1:0]  core_out_data,
    output logic           res_valid,
    output logic [DW-1:0]  res_data,
    output logic           busy,
    output logic           done,
    output logic           err_overlap,
    output logic           err_len,
    output logic           err_timeout
);

    // One shared counter covers both the launch gap and the result timeout.
    localparam int CMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]  GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [RCW-1:0] RES_LAST = RCW'(N_RES - 1);

    state_t          state;
    addr_t           idx;
    logic [CW-1:0]   cnt;
    logic [RCW-1:0]  rcnt;

    logic            wr_en;
    addr_t           rd_addr;
    logic [DW-1:0]   rd_data;
    logic [OPW-1:0]  rd_op;

    // Handshake and status are pure decodes of the state register, so they carry no input paths.
    assign h_ready = (state == S_LOAD);
    assign busy    = (state != S_LOAD);
    assign wr_en   = h_valid && (state == S_LOAD);

    // While sending, look one beat ahead so the registered outputs carry beat idx+1 next cycle.
    // Outside SEND the read port sits on entry 0, ready for the GAP->SEND launch.
    assign rd_addr = (state == S_SEND) ? (idx + addr_t'(1)) : '0;

    cg_pattern_buf u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (idx),
        .wr_data (h_data),
        .wr_op   (h_op),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_op   (rd_op)
    );

    // Main sequencer: load, gap, replay, wait for results, count them, final check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            idx         <= '0;
            cnt         <= '0;
            rcnt        <= '0;
            in_valid    <= 1'b0;
            in_data     <= '0;
            op          <= '0;
            done        <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (h_valid) begin
                        if (idx == LAST_ADDR) begin
                            idx   <= '0;
                            cnt   <= '0;
                            state <= S_GAP;
                        end else begin
                            idx <= idx + addr_t'(1);
                        end
                    end
                end

                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt      <= '0;
                        in_valid <= 1'b1;
                        in_data  <= rd_data;
                        op       <= rd_op;
                        state    <= S_SEND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // idx is the beat currently on the outputs; core_out_valid here only feeds the overlap monitor.
                S_SEND: begin
                    if (idx == LAST_ADDR) begin
                        idx      <= '0;
                        cnt      <= '0;
                        in_valid <= 1'b0;
                        in_data  <= '0;
                        op       <= '0;
                        state    <= S_WAIT;
                    end else begin
                        idx     <= idx + addr_t'(1);
                        in_data <= rd_data;
                        op      <= rd_op;
                    end
                end

                // A first result beat in the TIMEOUT-th waiting cycle is still accepted.
                S_WAIT: begin
                    if (core_out_valid) begin
                        rcnt  <= RCW'(1);
                        state <= S_RES;
                    end else if (cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= S_LOAD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                // rcnt holds beats already seen; a drop before N_RES is a short burst.
                S_RES: begin
                    if (!core_out_valid) begin
                        err_len <= 1'b1;
                        state   <= S_LOAD;
                    end else if (rcnt == RES_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        rcnt <= rcnt + RCW'(1);
                    end
                end

                // Any beat here means the core ran past N_RES.
                S_CHECK: begin
                    if (core_out_valid) begin
                        err_len <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                    idx   <= '0;
                    state <= S_LOAD;
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // Overlap monitor: the core must not answer while the burst is still on the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overlap <= 1'b0;
        end else if (core_out_valid && in_valid) begin
            err_overlap <= 1'b1;
        end
    end

    // Registered pass-through of the gating request and the core results, data zeroed when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cg_en     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            cg_en     <= cfg_cg_en;
            res_valid <= core_out_valid;
            res_data  <= core_out_valid ? core_out_data : '0;
        end
    end

endmodule

// File: tb/tb_cg_stim_feeder.sv
// Directed bench for cg_stim_feeder: host load, burst replay, result-burst error handling, mid-burst reset.
// Latency: expected timings are derived from GAP/TIMEOUT and the observed accept cycle.
// Backpressure: host driver waits on h_ready with a cycle bound.
module tb_cg_stim_feeder;
    import cg_pkg::*;

    localparam int G  = 2;
    localparam int TO = 1000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           cfg_cg_en = 1'b0;
    logic           h_valid = 1'b0;
    logic           h_ready;
    logic [DW-1:0]  h_data = '0;
    logic [OPW-1:0] h_op = '0;
    logic           cg_en;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic [OPW-1:0] op;
    logic           core_out_valid = 1'b0;
    logic [DW-1:0]  core_out_data = '0;
    logic           res_valid;
    logic [DW-1:0]  res_data;
    logic           busy;
    logic           done;
    logic           err_overlap;
    logic           err_len;
    logic           err_timeout;

    cg_stim_feeder #(.GAP(G), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_cg_en      (cfg_cg_en),
        .h_valid        (h_valid),
        .h_ready        (h_ready),
        .h_data         (h_data),
        .h_op           (h_op),
        .cg_en          (cg_en),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .op             (op),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .busy           (busy),
        .done           (done),
        .err_overlap    (err_overlap),
        .err_len        (err_len),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Monitor state: only the monitor writes these; the stimulus side reads them via base offsets.
    logic [DW-1:0]  in_q[$];
    logic [OPW-1:0] op_q[$];
    int             cyc_q[$];
    logic [DW-1:0]  res_q[$];
    int             res_cyc_q[$];
    int             cov_cyc_q[$];
    bit             hr_q[$];
    int             done_cnt = 0;
    int             idle_bad = 0;
    int             res_bad = 0;

    always @(negedge clk) begin
        if (in_valid) begin
            in_q.push_back(in_data);
            op_q.push_back(op);
            cyc_q.push_back(cyc);
        end else if (in_data !== '0 || op !== '0) begin
            idle_bad = idle_bad + 1;
        end
        if (res_valid) begin
            res_q.push_back(res_data);
            res_cyc_q.push_back(cyc);
        end else if (res_data !== '0) begin
            res_bad = res_bad + 1;
        end
        if (core_out_valid) cov_cyc_q.push_back(cyc);
        if (done) begin
            done_cnt = done_cnt + 1;
            hr_q.push_back(h_ready);
        end
    end

    int acc_cyc = 0;
    int in_base = 0;
    int res_base = 0;
    int cov_base = 0;
    int done_base = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int i, input bit inv);
        return inv ? DW'(31 - i) : DW'(i - 32);
    endfunction

    function automatic logic [OPW-1:0] exp_op(input int i, input bit inv);
        if (i >= N_OP) return '0;
        return inv ? OPW'((i + 3) % 16) : OPW'(i % 16);
    endfunction

    function automatic logic [DW-1:0] res_val(input int j);
        return DW'(j * 3 - 20);
    endfunction

    task automatic mark_bases();
        in_base   = in_q.size();
        res_base  = res_q.size();
        cov_base  = cov_cyc_q.size();
        done_base = done_cnt;
    endtask

    // Host driver: duty is the percent chance of offering a beat each cycle.
    task automatic load_pattern(input int duty, input bit inv);
        int waitc;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_DATA; i++) begin
            h_valid = 1'b0;
            while (int'($urandom_range(0, 99)) >= duty) begin
                @(posedge clk);
                #1;
            end
            h_valid = 1'b1;
            h_data  = exp_data(i, inv);
            h_op    = (i < N_OP) ? exp_op(i, inv) : 4'hA;
            @(negedge clk);
            waitc = 0;
            while (!h_ready && waitc < 50) begin
                @(negedge clk);
                waitc++;
            end
            if (!h_ready) begin
                check("load_hready_wait", 32'(h_ready), 32'd1);
                h_valid = 1'b0;
                return;
            end
            acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        h_valid = 1'b0;
        h_data  = '0;
        h_op    = '0;
    endtask

    // Returns in the first idle cycle after a full burst has been seen.
    task automatic wait_burst();
        bit seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (in_q.size() >= in_base + N_DATA && !in_valid) seen = 1'b1;
        end
        if (!seen) check("burst_wait", 32'(in_q.size() - in_base), 32'(N_DATA));
    endtask

    task automatic verify_burst(input bit inv);
        check("burst_len", 32'(in_q.size() - in_base), 32'(N_DATA));
        if (in_q.size() >= in_base + N_DATA) begin
            check("burst_start", 32'(cyc_q[in_base]), 32'(acc_cyc + G + 1));
            check("burst_contig", 32'(cyc_q[in_base + N_DATA - 1] - cyc_q[in_base]), 32'(N_DATA - 1));
            for (int k = 0; k < N_DATA; k++) begin
                check($sformatf("burst_data[%0d]", k), 32'(in_q[in_base + k]), 32'(exp_data(k, inv)));
                check($sformatf("burst_op[%0d]", k), 32'(op_q[in_base + k]), 32'(exp_op(k, inv)));
            end
        end
    endtask

    task automatic core_burst(input int delay, input int n);
        repeat (delay) @(posedge clk);
        #1;
        for (int j = 0; j < n; j++) begin
            core_out_valid = 1'b1;
            core_out_data  = res_val(j);
            @(posedge clk);
            #1;
        end
        core_out_valid = 1'b0;
        core_out_data  = '0;
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic verify_res(input int n);
        check("res_count", 32'(res_q.size() - res_base), 32'(n));
        if (res_q.size() >= res_base + n && cov_cyc_q.size() > cov_base) begin
            check("res_latency", 32'(res_cyc_q[res_base] - cov_cyc_q[cov_base]), 32'd1);
            for (int j = 0; j < n; j++) begin
                check($sformatf("res_data[%0d]", j), 32'(res_q[res_base + j]), 32'(res_val(j)));
            end
        end
    endtask

    task automatic do_reset();
        h_valid        = 1'b0;
        core_out_valid = 1'b0;
        core_out_data  = '0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int lcyc;
        int fcyc;
        int n_before;

        // Reset state.
        #1 rst_n = 1'b0;
        #11;
        check("rst_h_ready", 32'(h_ready), 32'd1);
        check("rst_outs", 32'({in_valid, busy, done, err_overlap, err_len, err_timeout, res_valid, cg_en}), 32'd0);
        check("rst_data", 32'({in_data, op, res_data}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // cg_en is cfg_cg_en delayed by one clock.
        @(posedge clk);
        #1;
        cfg_cg_en = 1'b1;
        @(negedge clk);
        check("cg_en_before_edge", 32'(cg_en), 32'd0);
        @(negedge clk);
        check("cg_en_after_edge", 32'(cg_en), 32'd1);

        // Back-to-back host beats, clean 16-beat result.
        mark_bases();
        load_pattern(100, 1'b0);
        @(negedge clk);
        check("h_ready_drop", 32'(h_ready), 32'd0);
        check("busy_gap", 32'(busy), 32'd1);
        wait_burst();
        verify_burst(1'b0);
        core_burst(20, 16);
        verify_res(16);
        check("t1_done_pulses", 32'(done_cnt - done_base), 32'd1);
        if (hr_q.size() > 0) check("t1_h_ready_at_done", 32'(hr_q[hr_q.size() - 1]), 32'd1);
        check("t1_errs", 32'({err_overlap, err_len, err_timeout}), 32'd0);
        check("t1_idle", 32'({h_ready, busy}), 32'b10);

        // Sparse host beats give the identical contiguous burst.
        mark_bases();
        load_pattern(30, 1'b0);
        wait_burst();
        verify_burst(1'b0);
        core_burst(5, 16);
        verify_res(16);
        check("t2_done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("t2_errs", 32'({err_overlap, err_len, err_timeout}), 32'd0);

        // Short result burst.
        mark_bases();
        load_pattern(100, 1'b1);
        wait_burst();
        verify_burst(1'b1);
        core_burst(3, 15);
        check("short_err_len", 32'(err_len), 32'd1);
        check("short_done", 32'(done_cnt - done_base), 32'd0);
        check("short_back_to_load", 32'({h_ready, busy}), 32'b10);

        // Overlong result burst.
        do_reset();
        check("reset_clears_err_len", 32'(err_len), 32'd0);
        mark_bases();
        load_pattern(100, 1'b0);
        wait_burst();
        core_burst(3, 17);
        check("long_err_len", 32'(err_len), 32'd1);
        check("long_done", 32'(done_cnt - done_base), 32'd0);
        check("long_back_to_load", 32'(h_ready), 32'd1);

        // Silent core: timeout.
        do_reset();
        mark_bases();
        load_pattern(100, 1'b0);
        wait_burst();
        lcyc = (cyc_q.size() > 0) ? cyc_q[cyc_q.size() - 1] : cyc;
        while (cyc < lcyc + TO - 1) begin
            @(negedge clk);
            #1;
        end
        check("timeout_not_yet", 32'(err_timeout), 32'd0);
        check("timeout_still_busy", 32'(busy), 32'd1);
        while (cyc < lcyc + TO + 1) begin
            @(negedge clk);
            #1;
        end
        check("timeout_flag", 32'(err_timeout), 32'd1);
        check("timeout_back_to_load", 32'(h_ready), 32'd1);

        // Core answers during burst beat 40.
        do_reset();
        mark_bases();
        load_pattern(100, 1'b0);
        fcyc = acc_cyc + G + 1;
        while (cyc < fcyc + 39) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        core_out_valid = 1'b1;
        core_out_data  = 7'd5;
        @(negedge clk);
        check("overlap_in_valid", 32'(in_valid), 32'd1);
        @(posedge clk);
        #1;
        core_out_valid = 1'b0;
        core_out_data  = '0;
        wait_burst();
        verify_burst(1'b0);
        check("overlap_flag", 32'(err_overlap), 32'd1);
        check("overlap_no_len", 32'(err_len), 32'd0);

        // Asynchronous reset at burst beat 30, then a fresh pattern.
        do_reset();
        mark_bases();
        load_pattern(100, 1'b0);
        fcyc = acc_cyc + G + 1;
        while (cyc < fcyc + 30) begin
            @(negedge clk);
            #1;
        end
        check("rst_mid_valid_pre", 32'(in_valid), 32'd1);
        n_before = in_q.size();
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 32'({in_valid, busy, done, err_overlap, err_len, err_timeout}), 32'd0);
        check("rst_mid_data", 32'({in_data, op}), 32'd0);
        check("rst_mid_h_ready", 32'(h_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("rst_mid_no_more_beats", 32'(in_q.size()), 32'(n_before));
        check("rst_mid_h_ready_after", 32'(h_ready), 32'd1);
        mark_bases();
        load_pattern(100, 1'b1);
        wait_burst();
        verify_burst(1'b1);
        core_burst(10, 16);
        verify_res(16);
        check("t7_done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("t7_errs", 32'({err_overlap, err_len, err_timeout}), 32'd0);

        // Idle-drive rules held for the whole run.
        check("idle_in_drive", 32'(idle_bad), 32'd0);
        check("idle_res_drive", 32'(res_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
